memory_arbiter: RTL and testbench
=================================

MEMORY_ARBITER -- requirements
Module: memory_arbiter

Interface
REQ-001 Parameter ADDR_W, default 10, SHALL set the word-address width (1024 words).
REQ-002 Parameter DATA_W, default 32, SHALL set the data width.
REQ-003 Parameter STARVE_MAX, default 3, SHALL set how many consecutive lost conflicts fetch tolerates before it wins.
REQ-004 clk  in  1  SHALL be the single clock; all state updates on posedge clk.
REQ-005 reset  in  1  SHALL be a synchronous, active-high reset.
REQ-006 fetchReq  in  1  SHALL be the instruction-fetch read request, held until granted.
REQ-007 fetchAddr  in  ADDR_W  SHALL be the fetch word address.
REQ-008 fetchGrant  out  1  SHALL indicate the fetch request is accepted this cycle.
REQ-009 fetchValid  out  1  SHALL be a one-cycle pulse marking fetchData valid.
REQ-010 fetchData  out  DATA_W  SHALL be the fetch read data.
REQ-011 dataReq  in  1  SHALL be the data-stage request, held until granted.
REQ-012 dataWrite  in  1  SHALL select write (1) or read (0) for dataReq.
REQ-013 dataAddr  in  ADDR_W  SHALL be the data word address.
REQ-014 dataWriteData  in  DATA_W  SHALL be the store data.
REQ-015 dataGrant  out  1  SHALL indicate the data request is accepted this cycle.
REQ-016 dataValid  out  1  SHALL be a one-cycle pulse acknowledging a data read or write.
REQ-017 dataReadData  out  DATA_W  SHALL be the data read result.
REQ-018 memEn, memWe  out  1 each  SHALL be the single-port memory enable and write enable.
REQ-019 memAddr  out  ADDR_W; memWdata  out  DATA_W  SHALL be the memory address and write data.
REQ-020 memRdata  in  DATA_W  SHALL be memory read data, valid the cycle after memEn with memWe=0.

Function
REQ-021 Grants, memEn, memWe, memAddr and memWdata SHALL be combinational from the current requests and registered arbiter state; at most one grant per cycle.
REQ-022 Only one requester active: it SHALL be granted the same cycle.
REQ-023 Both active: data SHALL win unless starveCnt == STARVE_MAX, in which case fetch wins.
REQ-024 starveCnt SHALL increment (saturating) on each cycle fetch loses a conflict, and SHALL clear on any fetch grant.
REQ-025 A fetch grant SHALL drive memEn=1, memWe=0, memAddr=fetchAddr.
REQ-026 A data grant SHALL drive memEn=1, memWe=dataWrite, memAddr=dataAddr, memWdata=dataWriteData.
REQ-027 No grant: memEn=0, memWe=0; memAddr and memWdata SHALL be 0.
REQ-028 A one-bit owner tag and a write flag SHALL be registered on each grant; the next cycle SHALL pulse exactly one of fetchValid/dataValid.
REQ-029 fetchData/dataReadData SHALL carry memRdata when their valid is high, and SHALL be 0 otherwise; dataValid after a write carries dataReadData=0.
REQ-030 Back-to-back grants SHALL be supported every cycle (throughput one access/cycle, read latency one cycle after grant).
REQ-031 Address wrap-around is not handled here: addresses pass through unmodified.
REQ-032 A requester dropping req in a cycle where it was not granted SHALL be allowed; no state changes result.

Reset
REQ-033 While reset=1: all grants, memEn, memWe, valids = 0; data outputs, memAddr, memWdata = 0; starveCnt = 0; owner pipeline cleared.
REQ-034 A grant in the cycle reset asserts SHALL NOT produce a valid pulse after reset.
REQ-035 The first cycle after reset deasserts SHALL arbitrate normally.

Structure
REQ-036 ADDR_W/DATA_W defaults and the owner encoding (OWN_FETCH=0, OWN_DATA=1) SHALL live in the shared processor constants package.
REQ-037 The starvation counter SHALL be one sub-module, starve_counter (saturating up-counter with clear).

Verification
REQ-038 fetchReq only, addr 5, memRdata 0xDEADBEEF next cycle -> fetchGrant same cycle; fetchValid=1 with fetchData=0xDEADBEEF next cycle.
REQ-039 dataReq write, addr 3, data 0x12345678 -> dataGrant, memWe=1, memAddr=3, memWdata=0x12345678; dataValid next cycle, fetchValid=0.
REQ-040 Both requests held 5 cycles, STARVE_MAX=3 -> grants D,D,D,F,D; starveCnt 1,2,3,0,1.
REQ-041 Alternating fetch/data reads each cycle -> one grant per cycle, valids alternate with correct data, no gaps.
REQ-042 Reset asserted in a fetch grant cycle -> fetchValid stays 0 the next cycle; all outputs 0 during reset.

Source files
------------

// File: rtl/memory_arbiter_pkg.sv
// Shared processor constants: default memory geometry, owner encoding and
// a helper for sizing the starvation counter.
package memory_arbiter_pkg;

  localparam int ADDR_W_DEF = 10;
  localparam int DATA_W_DEF = 32;

  typedef enum logic {
    OWN_FETCH = 1'b0,
    OWN_DATA  = 1'b1
  } owner_e;

  // Bits needed to hold 0..max_val; never less than one bit.
  function automatic int cnt_width(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/memory_arbiter_starve_counter.sv
// Saturating up-counter with synchronous clear; counts fetch conflict losses.
module starve_counter
  import memory_arbiter_pkg::*;
#(
  parameter int MAX = 3,
  parameter int W   = cnt_width(MAX)
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] count
);

  logic [W-1:0] count_reg;

  always_ff @(posedge clk) begin
    if (reset || clr) begin
      count_reg <= '0;
    end else if (inc && (count_reg != W'(MAX))) begin
      count_reg <= count_reg + 1'b1;
    end
  end

  assign count = count_reg;

endmodule

// File: rtl/memory_arbiter.sv
// Two-port (fetch/data) arbiter in front of a single-port synchronous memory.
// Data wins conflicts until fetch has lost STARVE_MAX in a row.
module memory_arbiter
  import memory_arbiter_pkg::*;
#(
  parameter int ADDR_W     = ADDR_W_DEF,
  parameter int DATA_W     = DATA_W_DEF,
  parameter int STARVE_MAX = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              fetchReq,
  input  logic [ADDR_W-1:0] fetchAddr,
  output logic              fetchGrant,
  output logic              fetchValid,
  output logic [DATA_W-1:0] fetchData,
  input  logic              dataReq,
  input  logic              dataWrite,
  input  logic [ADDR_W-1:0] dataAddr,
  input  logic [DATA_W-1:0] dataWriteData,
  output logic              dataGrant,
  output logic              dataValid,
  output logic [DATA_W-1:0] dataReadData,
  output logic              memEn,
  output logic              memWe,
  output logic [ADDR_W-1:0] memAddr,
  output logic [DATA_W-1:0] memWdata,
  input  logic [DATA_W-1:0] memRdata
);

  localparam int CNT_W = cnt_width(STARVE_MAX);

  logic [CNT_W-1:0] starve_cnt;
  logic             fetch_win;
  logic             data_win;
  logic             valid_reg;
  logic             write_reg;
  owner_e           owner_reg;

  // Reset gates arbitration so a request present during reset never issues.
  always_comb begin
    fetch_win = 1'b0;
    data_win  = 1'b0;
    if (!reset) begin
      if (fetchReq && (!dataReq || (starve_cnt == CNT_W'(STARVE_MAX)))) begin
        fetch_win = 1'b1;
      end else if (dataReq) begin
        data_win = 1'b1;
      end
    end
  end

  assign fetchGrant = fetch_win;
  assign dataGrant  = data_win;

  always_comb begin
    memEn    = 1'b0;
    memWe    = 1'b0;
    memAddr  = '0;
    memWdata = '0;
    if (fetch_win) begin
      memEn   = 1'b1;
      memAddr = fetchAddr;
    end else if (data_win) begin
      memEn    = 1'b1;
      memWe    = dataWrite;
      memAddr  = dataAddr;
      memWdata = dataWriteData;
    end
  end

  starve_counter #(
    .MAX (STARVE_MAX),
    .W   (CNT_W)
  ) u_starve_counter (
    .clk   (clk),
    .reset (reset),
    .inc   (fetchReq && data_win),
    .clr   (fetch_win),
    .count (starve_cnt)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_reg <= 1'b0;
      write_reg <= 1'b0;
      owner_reg <= OWN_FETCH;
    end else begin
      valid_reg <= fetch_win || data_win;
      write_reg <= data_win && dataWrite;
      owner_reg <= data_win ? OWN_DATA : OWN_FETCH;
    end
  end

  assign fetchValid   = !reset && valid_reg && (owner_reg == OWN_FETCH);
  assign dataValid    = !reset && valid_reg && (owner_reg == OWN_DATA);
  assign fetchData    = fetchValid ? memRdata : '0;
  // Write acknowledgements return zero rather than stale memory output.
  assign dataReadData = (dataValid && !write_reg) ? memRdata : '0;

endmodule

// File: tb/tb_memory_arbiter.sv
// Directed bench for memory_arbiter with a behavioural RAM and a scoreboard
// of expected valid pulses / read data.
module tb_memory_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        fetchReq;
  logic [9:0]  fetchAddr;
  logic        fetchGrant;
  logic        fetchValid;
  logic [31:0] fetchData;
  logic        dataReq;
  logic        dataWrite;
  logic [9:0]  dataAddr;
  logic [31:0] dataWriteData;
  logic        dataGrant;
  logic        dataValid;
  logic [31:0] dataReadData;
  logic        memEn;
  logic        memWe;
  logic [9:0]  memAddr;
  logic [31:0] memWdata;
  logic [31:0] memRdata = 32'h0;

  int tests = 0;
  int fails = 0;

  typedef struct {
    int          kind;   // 0 none, 1 fetch, 2 data
    logic [31:0] data;
  } exp_t;
  exp_t sb[$];

  bit [31:0] mem [1024];
  bit        written [1024];
  bit [31:0] ref_mem [1024];
  bit        ref_written [1024];

  always #5 clk = ~clk;

  memory_arbiter dut (
    .clk           (clk),
    .reset         (reset),
    .fetchReq      (fetchReq),
    .fetchAddr     (fetchAddr),
    .fetchGrant    (fetchGrant),
    .fetchValid    (fetchValid),
    .fetchData     (fetchData),
    .dataReq       (dataReq),
    .dataWrite     (dataWrite),
    .dataAddr      (dataAddr),
    .dataWriteData (dataWriteData),
    .dataGrant     (dataGrant),
    .dataValid     (dataValid),
    .dataReadData  (dataReadData),
    .memEn         (memEn),
    .memWe         (memWe),
    .memAddr       (memAddr),
    .memWdata      (memWdata),
    .memRdata      (memRdata)
  );

  function automatic logic [31:0] init_val(input logic [9:0] a);
    if (a == 10'd5) return 32'hDEADBEEF;
    return ({22'h0, a} * 32'h9E3779B1) ^ 32'h5A5A0000;
  endfunction

  function automatic logic [31:0] exp_read(input logic [9:0] a);
    return ref_written[a] ? ref_mem[a] : init_val(a);
  endfunction

  // Single-port synchronous RAM, one-cycle read latency.
  always @(posedge clk) begin
    if (memEn) begin
      if (memWe) begin
        mem[memAddr]     <= memWdata;
        written[memAddr] <= 1'b1;
      end else begin
        memRdata <= written[memAddr] ? mem[memAddr] : init_val(memAddr);
      end
    end
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_pop(input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      tests++;
      fails++;
      $error("FAIL %s: scoreboard empty got 1 expected 0", tag);
      return;
    end
    e = sb.pop_front();
    chk({tag, ".fetchValid"},   64'(fetchValid),   64'(e.kind == 1));
    chk({tag, ".dataValid"},    64'(dataValid),    64'(e.kind == 2));
    chk({tag, ".fetchData"},    64'(fetchData),    64'((e.kind == 1) ? e.data : 32'h0));
    chk({tag, ".dataReadData"}, 64'(dataReadData), 64'((e.kind == 2) ? e.data : 32'h0));
  endtask

  // One arbitration cycle: drive, check combinational side, push expectation,
  // clock, then check the response.
  task automatic step(input bit fr, input logic [9:0] fa, input bit dr, input bit dw,
                      input logic [9:0] da, input logic [31:0] dwd,
                      input bit ef, input bit ed, input string tag);
    exp_t e;
    fetchReq = fr; fetchAddr = fa;
    dataReq = dr; dataWrite = dw; dataAddr = da; dataWriteData = dwd;
    #1;
    chk({tag, ".fetchGrant"}, 64'(fetchGrant), 64'(ef));
    chk({tag, ".dataGrant"},  64'(dataGrant),  64'(ed));
    chk({tag, ".memEn"},      64'(memEn),      64'(ef | ed));
    chk({tag, ".memWe"},      64'(memWe),      64'(ed & dw));
    chk({tag, ".memAddr"},    64'(memAddr),    64'(ef ? fa : (ed ? da : 10'd0)));
    if (!ef) chk({tag, ".memWdata"}, 64'(memWdata), 64'(ed ? dwd : 32'h0));
    e.kind = ef ? 1 : (ed ? 2 : 0);
    e.data = ef ? exp_read(fa) : ((ed && !dw) ? exp_read(da) : 32'h0);
    sb.push_back(e);
    if (ed && dw) begin
      ref_mem[da]     = dwd;
      ref_written[da] = 1'b1;
    end
    $display("[TB] %s fr=%0b fa=%0d dr=%0b dw=%0b da=%0d grant f=%0b d=%0b exp_data=%h",
             tag, fr, fa, dr, dw, da, fetchGrant, dataGrant, e.data);
    @(posedge clk);
    #1;
    check_pop(tag);
  endtask

  initial begin
    reset = 1'b1;
    fetchReq = 1'b0; fetchAddr = '0;
    dataReq = 1'b0; dataWrite = 1'b0; dataAddr = '0; dataWriteData = '0;
    repeat (2) @(posedge clk);
    #1;

    // Requests present during reset must be ignored.
    fetchReq = 1'b1; fetchAddr = 10'd9;
    dataReq = 1'b1; dataWrite = 1'b1; dataAddr = 10'd8; dataWriteData = 32'hCAFE0001;
    #1;
    chk("rst.fetchGrant", 64'(fetchGrant), 64'(0));
    chk("rst.dataGrant",  64'(dataGrant),  64'(0));
    chk("rst.memEn",      64'(memEn),      64'(0));
    chk("rst.memWe",      64'(memWe),      64'(0));
    chk("rst.memAddr",    64'(memAddr),    64'(0));
    chk("rst.memWdata",   64'(memWdata),   64'(0));
    chk("rst.fetchValid", 64'(fetchValid), 64'(0));
    chk("rst.dataValid",  64'(dataValid),  64'(0));
    $display("[TB] reset state sampled");
    @(posedge clk);
    #1;
    reset = 1'b0;

    step(1, 10'd5, 0, 0, 10'd0, 32'h0, 1, 0, "fetch5");
    step(0, 10'd0, 1, 1, 10'd3, 32'h12345678, 0, 1, "write3");
    step(0, 10'd0, 0, 0, 10'd0, 32'h0, 0, 0, "idle");
    step(0, 10'd0, 1, 0, 10'd3, 32'h0, 0, 1, "read3");

    for (int i = 0; i < 5; i++)
      step(1, 10'd7, 1, 0, 10'(50 + i), 32'h0, i == 3, i != 3, $sformatf("starve%0d", i));

    for (int i = 0; i < 6; i++) begin
      if (i % 2 == 0) step(1, 10'(40 + i), 0, 0, 10'd0, 32'h0, 1, 0, $sformatf("alt%0d", i));
      else            step(0, 10'd0, 1, 0, 10'(100 + i), 32'h0, 0, 1, $sformatf("alt%0d", i));
    end

    step(0, 10'd0, 1, 1, 10'd1023, 32'hA5A5C3C3, 0, 1, "write1023");
    step(1, 10'd1023, 0, 0, 10'd0, 32'h0, 1, 0, "fetch1023");
    step(1, 10'd12, 1, 1, 10'd0, 32'h0BADF00D, 0, 1, "confw0");
    step(1, 10'd12, 0, 0, 10'd0, 32'h0, 1, 0, "fetch12");
    step(0, 10'd0, 1, 0, 10'd0, 32'h0, 0, 1, "read0");

    // Build up starvation, then reset right after a fetch grant.
    step(1, 10'd2, 1, 0, 10'd60, 32'h0, 0, 1, "pre0");
    step(1, 10'd2, 1, 0, 10'd61, 32'h0, 0, 1, "pre1");
    fetchReq = 1'b1; fetchAddr = 10'd20; dataReq = 1'b0;
    #1;
    chk("rg.fetchGrant", 64'(fetchGrant), 64'(1));
    @(posedge clk);
    #1;
    reset = 1'b1;
    fetchAddr = 10'd21;
    #1;
    chk("rg.rst.fetchValid", 64'(fetchValid), 64'(0));
    chk("rg.rst.fetchData",  64'(fetchData),  64'(0));
    chk("rg.rst.fetchGrant", 64'(fetchGrant), 64'(0));
    chk("rg.rst.memEn",      64'(memEn),      64'(0));
    chk("rg.rst.memAddr",    64'(memAddr),    64'(0));
    $display("[TB] reset during fetch grant sampled");
    @(posedge clk);
    #1;
    reset = 1'b0;
    chk("rg.post.fetchValid", 64'(fetchValid), 64'(0));
    chk("rg.post.dataValid",  64'(dataValid),  64'(0));

    // Counter must restart from zero: D,D,D then F.
    for (int i = 0; i < 4; i++)
      step(1, 10'd30, 1, 0, 10'(70 + i), 32'h0, i == 3, i != 3, $sformatf("post%0d", i));

    tests++;
    assert (sb.size() == 0) else begin
      fails++;
      $error("FAIL drain: leftover %0d expected 0", sb.size());
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
